// File: rtl/ethernet_sys_instr_ram_arbiter.sv
`default_nettype none
// ============================================================================
// ethernet_sys_instr_ram_arbiter
// Shares the single-port instruction RAM between Nios fetch (C) and the
// firmware loader (L), with bounded-run fairness and an exclusive reload lock.
// Rev 1.0
// ============================================================================
module ethernet_sys_instr_ram_arbiter #(
  parameter int ADDR_W          = 13,
  parameter int DATA_W          = 32,
  parameter int MAX_RUN         = 4,
  parameter int WR_REQUIRE_LOCK = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   c_address,
  input  logic                c_read,
  output logic                c_waitrequest,
  output logic [DATA_W-1:0]   c_readdata,
  output logic                c_readdatavalid,
  input  logic [ADDR_W-1:0]   l_address,
  input  logic                l_read,
  input  logic                l_write,
  input  logic [DATA_W/8-1:0] l_byteenable,
  input  logic [DATA_W-1:0]   l_writedata,
  output logic                l_waitrequest,
  output logic [DATA_W-1:0]   l_readdata,
  output logic                l_readdatavalid,
  input  logic                lock_req,
  output logic                lock_gnt,
  output logic                wr_err,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam logic [3:0] C_MAX_RUN = 4'(MAX_RUN);

  typedef enum logic [1:0] {
    SHARED = 2'd0,
    DRAIN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_lock_gnt;
  logic       r_wr_err;
  logic       r_rsel_c;
  logic       r_rsel_l;
  logic       r_last_c;
  logic [3:0] r_run_cnt;

  logic w_req_c;
  logic w_req_l;
  logic w_grant_c;
  logic w_grant_l;
  logic w_keep_last;
  logic w_drop_wr;

  assign w_req_c = c_read;
  assign w_req_l = l_read | l_write;

  // A zero run count means the previous run ended with an idle cycle, so a
  // tie then goes to the master that was not granted last (C right after reset).
  assign w_keep_last = (r_run_cnt != 4'd0) && (r_run_cnt < C_MAX_RUN);

  always_comb begin
    w_grant_c = 1'b0;
    w_grant_l = 1'b0;
    if (reset_n) begin
      if (r_state == SHARED) begin
        if (w_req_c && w_req_l) begin
          if (r_last_c) begin
            w_grant_c = w_keep_last;
            w_grant_l = !w_keep_last;
          end else begin
            w_grant_l = w_keep_last;
            w_grant_c = !w_keep_last;
          end
        end else begin
          w_grant_c = w_req_c;
          w_grant_l = w_req_l;
        end
      end else begin
        w_grant_l = w_req_l;
      end
    end
  end

  assign w_drop_wr = (WR_REQUIRE_LOCK != 0) && w_grant_l && l_write && (r_state != LOCKED);

  always_comb begin
    ram_address    = c_address;
    ram_chipselect = w_grant_c;
    ram_write      = 1'b0;
    ram_byteenable = '1;
    ram_writedata  = l_writedata;
    if (w_grant_l) begin
      ram_address    = l_address;
      ram_chipselect = !w_drop_wr;
      ram_write      = l_write && !w_drop_wr;
      ram_byteenable = l_byteenable;
    end
  end

  // C can never be granted in DRAIN, so once there the only outstanding
  // C read is the one returning this cycle and DRAIN lasts a single cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SHARED: if (lock_req) w_state_nxt = DRAIN;
      DRAIN: begin
        if (!lock_req)       w_state_nxt = SHARED;
        else if (!w_grant_c) w_state_nxt = LOCKED;
      end
      LOCKED: if (!lock_req) w_state_nxt = SHARED;
      default: w_state_nxt = SHARED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= SHARED;
      r_lock_gnt <= 1'b0;
      r_wr_err   <= 1'b0;
      r_rsel_c   <= 1'b0;
      r_rsel_l   <= 1'b0;
      r_last_c   <= 1'b0;
      r_run_cnt  <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_gnt <= (w_state_nxt == LOCKED);
      r_rsel_c   <= w_grant_c;
      r_rsel_l   <= w_grant_l && !l_write;
      if (w_drop_wr) begin
        r_wr_err <= 1'b1;
      end else if ((r_state != LOCKED) && (w_state_nxt == LOCKED)) begin
        r_wr_err <= 1'b0;
      end
      if (w_grant_c || w_grant_l) begin
        if (w_grant_c == r_last_c) begin
          if (r_run_cnt != 4'hF) r_run_cnt <= r_run_cnt + 4'd1;
        end else begin
          r_run_cnt <= 4'd1;
          r_last_c  <= w_grant_c;
        end
      end else begin
        r_run_cnt <= 4'd0;
      end
    end
  end

  assign c_waitrequest   = w_req_c && !w_grant_c;
  assign l_waitrequest   = w_req_l && !w_grant_l;
  assign c_readdata      = ram_readdata;
  assign l_readdata      = ram_readdata;
  assign c_readdatavalid = r_rsel_c;
  assign l_readdatavalid = r_rsel_l;
  assign lock_gnt        = r_lock_gnt;
  assign wr_err          = r_wr_err;
  assign ram_clken       = reset_n;

endmodule
`default_nettype wire

// File: tb/tb_ethernet_sys_instr_ram_arbiter.sv
`default_nettype none
// Randomized self-checking bench: a RAM image model plus grant-pattern
// arithmetic predict every grant, read return and lock transition.
module tb_ethernet_sys_instr_ram_arbiter;

  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 32;
  localparam int MAX_RUN = 4;
  localparam int DEPTH   = 8192;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] c_address = '0;
  logic              c_read = 1'b0;
  logic              c_waitrequest;
  logic [DATA_W-1:0] c_readdata;
  logic              c_readdatavalid;
  logic [ADDR_W-1:0] l_address = '0;
  logic              l_read = 1'b0;
  logic              l_write = 1'b0;
  logic [3:0]        l_byteenable = 4'hF;
  logic [DATA_W-1:0] l_writedata = '0;
  logic              l_waitrequest;
  logic [DATA_W-1:0] l_readdata;
  logic              l_readdatavalid;
  logic              lock_req = 1'b0;
  logic              lock_gnt;
  logic              wr_err;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect;
  logic              ram_write;
  logic [3:0]        ram_byteenable;
  logic [DATA_W-1:0] ram_writedata;
  logic              ram_clken;
  logic [DATA_W-1:0] ram_readdata = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] exp_mem [0:DEPTH-1];

  always #5 clk = ~clk;

  ethernet_sys_instr_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RUN(MAX_RUN), .WR_REQUIRE_LOCK(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .c_address(c_address), .c_read(c_read), .c_waitrequest(c_waitrequest),
    .c_readdata(c_readdata), .c_readdatavalid(c_readdatavalid),
    .l_address(l_address), .l_read(l_read), .l_write(l_write),
    .l_byteenable(l_byteenable), .l_writedata(l_writedata),
    .l_waitrequest(l_waitrequest), .l_readdata(l_readdata),
    .l_readdatavalid(l_readdatavalid),
    .lock_req(lock_req), .lock_gnt(lock_gnt), .wr_err(wr_err),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );

  function automatic logic [31:0] apply_be(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
    return old;
  endfunction

  // Synchronous single-port RAM: address registered, q valid next cycle.
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) mem[ram_address] <= apply_be(mem[ram_address], ram_writedata, ram_byteenable);
      else           ram_readdata <= mem[ram_address];
    end
  end

  task automatic test_reset();
    #1; c_read = 1'b1; l_read = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({c_waitrequest, l_waitrequest, ram_chipselect, ram_clken} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_grants: wait_c/wait_l/cs/clken=%b%b%b%b, want 1100",
               c_waitrequest, l_waitrequest, ram_chipselect, ram_clken);
    end
    n_cmp++;
    if ({lock_gnt, wr_err, c_readdatavalid, l_readdatavalid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_regs: gnt/err/cv/lv=%b%b%b%b, want 0000",
               lock_gnt, wr_err, c_readdatavalid, l_readdatavalid);
    end
    c_read = 1'b0; l_read = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ram_clken, c_readdatavalid, l_readdatavalid} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release: clken/cv/lv=%b%b%b, want 100", ram_clken, c_readdatavalid, l_readdatavalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_c_stream();
    bit          pv;
    logic [31:0] pd;
    pv = 1'b0; pd = '0;
    for (int k = 0; k < 5; k++) begin
      c_read = (k < 4); c_address = 13'(k);
      @(negedge clk);
      if (k < 4) begin
        n_cmp++;
        if (c_waitrequest !== 1'b0) begin
          n_fail++; $display("FAIL cstream_wait[%0d]: got %b, want 0", k, c_waitrequest);
        end
      end
      n_cmp++;
      if ({c_readdatavalid, l_readdatavalid} !== {pv, 1'b0} || (pv && c_readdata !== pd)) begin
        n_fail++;
        $display("FAIL cstream_data[%0d]: cv/lv=%b%b data=%h, want %b0 %h",
                 k, c_readdatavalid, l_readdatavalid, c_readdata, pv, pd);
      end
      pv = (k < 4); pd = exp_mem[k];
      @(posedge clk); #1;
    end
  endtask

  // Both masters read continuously: grants alternate in blocks of MAX_RUN.
  task automatic test_fairness(input bit first_c);
    logic [ADDR_W-1:0] ca, la;
    logic [31:0]       pd;
    bit                pv_c, pv_l, win_c;
    int                cw, lw, maxw;
    ca = 13'($urandom); la = 13'($urandom); pd = '0;
    pv_c = 1'b0; pv_l = 1'b0; cw = 0; lw = 0; maxw = 0;
    for (int g = 0; g <= 16; g++) begin
      c_read = (g < 16); l_read = (g < 16); c_address = ca; l_address = la;
      @(negedge clk);
      win_c = first_c ^ (((g / MAX_RUN) % 2) == 1);
      if (g < 16) begin
        n_cmp++;
        if ({c_waitrequest, l_waitrequest} !== {!win_c, win_c}) begin
          n_fail++;
          $display("FAIL fair_grant[%0d]: wait c/l=%b%b, want %b%b", g, c_waitrequest, l_waitrequest, !win_c, win_c);
        end
        cw = c_waitrequest ? cw + 1 : 0;
        lw = l_waitrequest ? lw + 1 : 0;
        if (cw > maxw) maxw = cw;
        if (lw > maxw) maxw = lw;
      end
      n_cmp++;
      if ({c_readdatavalid, l_readdatavalid} !== {pv_c, pv_l} ||
          (pv_c && c_readdata !== pd) || (pv_l && l_readdata !== pd)) begin
        n_fail++;
        $display("FAIL fair_data[%0d]: cv/lv=%b%b cd=%h ld=%h, want %b%b %h",
                 g, c_readdatavalid, l_readdatavalid, c_readdata, l_readdata, pv_c, pv_l, pd);
      end
      pv_c = (g < 16) && win_c;
      pv_l = (g < 16) && !win_c;
      if (g < 16) begin
        pd = exp_mem[win_c ? ca : la];
        if (win_c) ca = 13'($urandom); else la = 13'($urandom);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (maxw > MAX_RUN) begin
      n_fail++; $display("FAIL fair_maxwait: got %0d, want <= %0d", maxw, MAX_RUN);
    end
  endtask

  task automatic test_write_protect();
    l_write = 1'b1; l_address = 13'h1FFF; l_writedata = 32'hDEADBEEF; l_byteenable = 4'hF;
    @(negedge clk);
    n_cmp++;
    if ({l_waitrequest, ram_chipselect, ram_write} !== 3'b000) begin
      n_fail++;
      $display("FAIL wp_drop: wait/cs/we=%b%b%b, want 000", l_waitrequest, ram_chipselect, ram_write);
    end
    @(posedge clk); #1;
    l_write = 1'b0; l_read = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({wr_err, l_waitrequest, c_readdatavalid, l_readdatavalid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL wp_err: err/wait/cv/lv=%b%b%b%b, want 1000", wr_err, l_waitrequest, c_readdatavalid, l_readdatavalid);
    end
    @(posedge clk); #1;
    l_read = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (l_readdatavalid !== 1'b1 || l_readdata !== exp_mem[13'h1FFF]) begin
      n_fail++;
      $display("FAIL wp_readback: lv=%b data=%h, want 1 %h", l_readdatavalid, l_readdata, exp_mem[13'h1FFF]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lock_and_write(input logic [ADDR_W-1:0] ca, input logic [ADDR_W-1:0] wa);
    c_read = 1'b1; c_address = ca; lock_req = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (c_waitrequest !== 1'b0) begin
      n_fail++; $display("FAIL lock_cfirst: wait=%b, want 0", c_waitrequest);
    end
    @(posedge clk); #1;
    c_address = ca + 13'd1;
    @(negedge clk);
    n_cmp++;
    if ({c_waitrequest, lock_gnt, c_readdatavalid} !== 3'b101 || c_readdata !== exp_mem[ca]) begin
      n_fail++;
      $display("FAIL lock_drain: wait/gnt/cv=%b%b%b data=%h, want 101 %h",
               c_waitrequest, lock_gnt, c_readdatavalid, c_readdata, exp_mem[ca]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({lock_gnt, wr_err, c_waitrequest} !== 3'b101) begin
      n_fail++;
      $display("FAIL lock_gnt: gnt/err/wait=%b%b%b, want 101", lock_gnt, wr_err, c_waitrequest);
    end
    @(posedge clk); #1;
    l_write = 1'b1; l_address = wa; l_writedata = 32'h12345678; l_byteenable = 4'h3;
    @(negedge clk);
    n_cmp++;
    if ({l_waitrequest, ram_chipselect, ram_write, c_waitrequest} !== 4'b0111 ||
        ram_byteenable !== 4'h3 || ram_address !== wa) begin
      n_fail++;
      $display("FAIL lock_write: wait/cs/we/cwait=%b%b%b%b be=%h addr=%h, want 0111 3 %h",
               l_waitrequest, ram_chipselect, ram_write, c_waitrequest, ram_byteenable, ram_address, wa);
    end
    exp_mem[wa] = {exp_mem[wa][31:16], 16'h5678};
    @(posedge clk); #1;
    l_write = 1'b0; l_read = 1'b1; l_byteenable = 4'hF;
    @(negedge clk);
    n_cmp++;
    if ({l_waitrequest, wr_err} !== 2'b00) begin
      n_fail++; $display("FAIL lock_read: wait/err=%b%b, want 00", l_waitrequest, wr_err);
    end
    @(posedge clk); #1;
    l_read = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({l_readdatavalid, c_readdatavalid, c_waitrequest} !== 3'b101 || l_readdata !== exp_mem[wa]) begin
      n_fail++;
      $display("FAIL lock_readback: lv/cv/cwait=%b%b%b data=%h, want 101 %h",
               l_readdatavalid, c_readdatavalid, c_waitrequest, l_readdata, exp_mem[wa]);
    end
    @(posedge clk); #1;
  endtask

  // C is still holding address ca+1 from the locked phase.
  task automatic test_unlock(input logic [ADDR_W-1:0] ca, input logic [ADDR_W-1:0] wa);
    lock_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({lock_gnt, c_waitrequest} !== 2'b11) begin
      n_fail++; $display("FAIL unlock_hold: gnt/wait=%b%b, want 11", lock_gnt, c_waitrequest);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({lock_gnt, c_waitrequest} !== 2'b00) begin
      n_fail++; $display("FAIL unlock_drop: gnt/wait=%b%b, want 00", lock_gnt, c_waitrequest);
    end
    @(posedge clk); #1;
    c_address = wa;
    @(negedge clk);
    n_cmp++;
    if ({c_readdatavalid, c_waitrequest} !== 2'b10 || c_readdata !== exp_mem[ca + 13'd1]) begin
      n_fail++;
      $display("FAIL unlock_resume: cv/wait=%b%b data=%h, want 10 %h",
               c_readdatavalid, c_waitrequest, c_readdata, exp_mem[ca + 13'd1]);
    end
    @(posedge clk); #1;
    c_read = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (c_readdatavalid !== 1'b1 || c_readdata !== exp_mem[wa]) begin
      n_fail++;
      $display("FAIL unlock_newword: cv=%b data=%h, want 1 %h", c_readdatavalid, c_readdata, exp_mem[wa]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    logic [ADDR_W-1:0] ca, la;
    ca = 13'($urandom); la = 13'($urandom);
    lock_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    l_read = 1'b1; l_address = la;
    @(negedge clk);
    n_cmp++;
    if ({lock_gnt, l_waitrequest} !== 2'b10) begin
      n_fail++; $display("FAIL midop_setup: gnt/wait=%b%b, want 10", lock_gnt, l_waitrequest);
    end
    @(posedge clk); #1;
    l_read = 1'b0; lock_req = 1'b0; reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({l_readdatavalid, lock_gnt, ram_clken} !== 3'b000) begin
      n_fail++;
      $display("FAIL midop_async: lv/gnt/clken=%b%b%b, want 000", l_readdatavalid, lock_gnt, ram_clken);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({l_readdatavalid, c_readdatavalid, lock_gnt, wr_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midop_after: lv/cv/gnt/err=%b%b%b%b, want 0000", l_readdatavalid, c_readdatavalid, lock_gnt, wr_err);
    end
    @(posedge clk); #1;
    c_read = 1'b1; c_address = ca; l_read = 1'b1; l_address = la;
    @(negedge clk);
    n_cmp++;
    if ({c_waitrequest, l_waitrequest} !== 2'b01) begin
      n_fail++; $display("FAIL midop_firsttie: wait c/l=%b%b, want 01", c_waitrequest, l_waitrequest);
    end
    @(posedge clk); #1;
    c_read = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({c_readdatavalid, l_waitrequest} !== 2'b10 || c_readdata !== exp_mem[ca]) begin
      n_fail++;
      $display("FAIL midop_cdata: cv/lwait=%b%b data=%h, want 10 %h", c_readdatavalid, l_waitrequest, c_readdata, exp_mem[ca]);
    end
    @(posedge clk); #1;
    l_read = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (l_readdatavalid !== 1'b1 || l_readdata !== exp_mem[la]) begin
      n_fail++;
      $display("FAIL midop_ldata: lv=%b data=%h, want 1 %h", l_readdatavalid, l_readdata, exp_mem[la]);
    end
    @(posedge clk); #1;
  endtask

  // Random read traffic from both masters, Avalon hold-until-accepted.
  task automatic test_random(input int cycles);
    logic [ADDR_W-1:0] ca, la;
    logic [31:0]       pdc, pdl;
    bit                ca_on, la_on, pv_c, pv_l, gc, gl;
    int                cw, lw, maxw;
    ca = '0; la = '0; pdc = '0; pdl = '0;
    ca_on = 1'b0; la_on = 1'b0; pv_c = 1'b0; pv_l = 1'b0; cw = 0; lw = 0; maxw = 0;
    for (int k = 0; k < cycles + 12; k++) begin
      if (!ca_on && k < cycles && $urandom_range(0, 3) != 0) begin ca_on = 1'b1; ca = 13'($urandom); end
      if (!la_on && k < cycles && $urandom_range(0, 3) != 0) begin la_on = 1'b1; la = 13'($urandom); end
      c_read = ca_on; c_address = ca; l_read = la_on; l_address = la;
      @(negedge clk);
      gc = ca_on && !c_waitrequest;
      gl = la_on && !l_waitrequest;
      if (ca_on || la_on) begin
        n_cmp++;
        if (!(gc ^ gl)) begin
          n_fail++;
          $display("FAIL rnd_grant[%0d]: req c/l=%b%b wait c/l=%b%b, want exactly one grant",
                   k, ca_on, la_on, c_waitrequest, l_waitrequest);
        end
      end
      n_cmp++;
      if ({c_readdatavalid, l_readdatavalid} !== {pv_c, pv_l} ||
          (pv_c && c_readdata !== pdc) || (pv_l && l_readdata !== pdl)) begin
        n_fail++;
        $display("FAIL rnd_data[%0d]: cv/lv=%b%b cd=%h ld=%h, want %b%b %h %h",
                 k, c_readdatavalid, l_readdatavalid, c_readdata, l_readdata, pv_c, pv_l, pdc, pdl);
      end
      cw = (ca_on && !gc) ? cw + 1 : 0;
      lw = (la_on && !gl) ? lw + 1 : 0;
      if (cw > maxw) maxw = cw;
      if (lw > maxw) maxw = lw;
      pv_c = gc; pv_l = gl;
      if (gc) begin pdc = exp_mem[ca]; ca_on = 1'b0; end
      if (gl) begin pdl = exp_mem[la]; la_on = 1'b0; end
      @(posedge clk); #1;
    end
    c_read = 1'b0; l_read = 1'b0;
    n_cmp++;
    if (ca_on || la_on || maxw > MAX_RUN) begin
      n_fail++;
      $display("FAIL rnd_progress: pending c/l=%b%b maxwait=%0d, want 00 and <= %0d", ca_on, la_on, maxw, MAX_RUN);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'(i) * 32'h9E3779B1 + 32'h01234567;
      exp_mem[i] = 32'(i) * 32'h9E3779B1 + 32'h01234567;
    end
    test_reset();
    test_c_stream();
    test_fairness(1'b0);
    test_write_protect();
    test_lock_and_write(13'h0100, 13'h0040);
    test_unlock(13'h0100, 13'h0040);
    test_reset_midop();
    test_random(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
